// File: rtl/acc_proc_param.sv
// acc_proc_param: parametrised accumulator processor with an 8-op ISA,
// zero/carry flags, start/busy/done handshake and a program-load port.
// Ports:
//   clk, rst (sync, active-high)
//   start             begin execution at address 0 (ignored while busy)
//   prog_we/adr/din   program-port write (ignored while busy)
//   prog_dout         mem[prog_adr], combinational
//   busy, done        FETCH/EXEC and DONE state indicators
//   acc, pc, zf, cf   architectural state
//   mem_adr, mem_rd, mem_wr  memory bus observation
module acc_proc_param #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_adr,
    input  logic [DW-1:0] prog_din,
    output logic [DW-1:0] prog_dout,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] acc,
    output logic [AW-1:0] pc,
    output logic          zf,
    output logic          cf,
    output logic [AW-1:0] mem_adr,
    output logic          mem_rd,
    output logic          mem_wr
);

    localparam int DEPTH = 1 << AW;

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_STA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_JZ  = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ir, ir_n, acc_n;
    logic [AW-1:0] pc_n;
    logic          zf_n, cf_n;
    logic [DW-1:0] wdata, mem_q, opnd;
    logic [DW:0]   sum;
    logic [2:0]    op;
    logic [AW-1:0] ir_adr;
    logic          is_sub;

    assign op     = ir[DW-1 -: 3];
    assign ir_adr = ir[AW-1:0];
    assign is_sub = (op == OP_SUB);

    assign mem_q     = mem[mem_adr];
    assign prog_dout = mem[prog_adr];

    // SUB is acc + ~M + 1 so the carry out doubles as "no borrow".
    assign opnd = is_sub ? ~mem_q : mem_q;
    assign sum  = {1'b0, acc} + {1'b0, opnd} + {{DW{1'b0}}, is_sub};

    assign busy = (state == FETCH) || (state == EXEC);
    assign done = (state == DONE);

    // Memory bus steering; program port owns the bus only when not busy.
    always_comb begin
        mem_adr = prog_adr;
        mem_rd  = 1'b0;
        mem_wr  = prog_we;
        wdata   = prog_din;
        unique case (state)
            FETCH: begin
                mem_adr = pc;
                mem_rd  = 1'b1;
                mem_wr  = 1'b0;
            end
            EXEC: begin
                mem_adr = ir_adr;
                mem_rd  = (op == OP_LDA) || (op == OP_ADD) ||
                          (op == OP_SUB) || (op == OP_AND);
                mem_wr  = (op == OP_STA);
                wdata   = acc;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        acc_n   = acc;
        ir_n    = ir;
        zf_n    = zf;
        cf_n    = cf;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = FETCH;
                    pc_n    = '0;
                    acc_n   = '0;
                    ir_n    = '0;
                    zf_n    = 1'b0;
                    cf_n    = 1'b0;
                end
            end
            FETCH: begin
                ir_n    = mem_q;
                pc_n    = pc + AW'(1);
                state_n = EXEC;
            end
            EXEC: begin
                state_n = FETCH;
                unique case (op)
                    OP_LDA: begin
                        acc_n = mem_q;
                        zf_n  = (mem_q == '0);
                    end
                    OP_STA: ;
                    OP_ADD, OP_SUB: begin
                        acc_n = sum[DW-1:0];
                        zf_n  = (sum[DW-1:0] == '0);
                        cf_n  = sum[DW];
                    end
                    OP_AND: begin
                        acc_n = acc & mem_q;
                        zf_n  = ((acc & mem_q) == '0);
                    end
                    OP_JMP: pc_n = ir_adr;
                    OP_JZ:  if (zf) pc_n = ir_adr;
                    OP_HLT: state_n = DONE;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            acc   <= '0;
            ir    <= '0;
            zf    <= 1'b0;
            cf    <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            acc   <= acc_n;
            ir    <= ir_n;
            zf    <= zf_n;
            cf    <= cf_n;
        end
    end

    // Memory is never cleared; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr)
            mem[mem_adr] <= wdata;
    end

endmodule

// File: tb/tb_acc_proc_param.sv
// tb_acc_proc_param: self-checking bench for acc_proc_param (DW=8, AW=5).
// Directed scenarios plus random straight-line programs vs. an ISA model.
module tb_acc_proc_param;

    localparam int LIMIT = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       prog_we;
    logic [4:0] prog_adr;
    logic [7:0] prog_din;
    logic [7:0] prog_dout;
    logic       busy, done;
    logic [7:0] acc;
    logic [4:0] pc;
    logic       zf, cf;
    logic [4:0] mem_adr;
    logic       mem_rd, mem_wr;

    int n_checks = 0;
    int n_fail   = 0;

    int ref_mem [32];
    int m_acc, m_pc, m_steps;
    bit m_zf, m_cf;

    acc_proc_param #(.DW(8), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .prog_we(prog_we), .prog_adr(prog_adr), .prog_din(prog_din),
        .prog_dout(prog_dout), .busy(busy), .done(done),
        .acc(acc), .pc(pc), .zf(zf), .cf(cf),
        .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    task automatic load(input int a, input int d);
        @(negedge clk);
        prog_we  = 1'b1;
        prog_adr = 5'(a);
        prog_din = 8'(d);
        @(negedge clk);
        prog_we  = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic peek(input int a, output logic [7:0] d);
        prog_adr = 5'(a);
        #1;
        d = prog_dout;
    endtask

    // Pulses start; returns edges from the start edge until done is seen.
    task automatic run_prog(output int edges, output logic d0, output logic b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done;
        b0 = busy;
        edges = 0;
        while (done !== 1'b1 && edges < LIMIT) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // ISA-level reference: interprets ref_mem from address 0 until HLT.
    task automatic model_run();
        int  p, ir, op, a, m;
        bit  halt;
        p = 0; m_acc = 0; m_zf = 0; m_cf = 0; m_steps = 0; halt = 0;
        while (!halt && m_steps < LIMIT) begin
            ir = ref_mem[p];
            p  = (p + 1) % 32;
            op = ir / 32;
            a  = ir % 32;
            m  = ref_mem[a];
            m_steps++;
            case (op)
                0: begin m_acc = m; m_zf = (m_acc == 0); end
                1: ref_mem[a] = m_acc;
                2: begin
                    m_cf  = (m_acc + m) > 255;
                    m_acc = (m_acc + m) % 256;
                    m_zf  = (m_acc == 0);
                end
                3: begin
                    m_cf  = (m_acc >= m);
                    m_acc = (m_acc - m + 256) % 256;
                    m_zf  = (m_acc == 0);
                end
                4: begin m_acc = m_acc & m; m_zf = (m_acc == 0); end
                5: p = a;
                6: if (m_zf) p = a;
                default: halt = 1;
            endcase
        end
        m_pc = p;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1; start = 1'b0; prog_we = 1'b0;
        prog_adr = '0; prog_din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, mem_rd, zf, cf} !== 5'b0 || pc !== 5'd0 || acc !== 8'd0) begin
            $display("FAIL reset_state got b%b d%b r%b z%b c%b pc=%0d acc=%h exp all 0",
                     busy, done, mem_rd, zf, cf, pc, acc);
            n_fail++;
        end
        load(5, 8'h55);
        @(negedge clk);
        rst = 1'b1; prog_we = 1'b1; prog_adr = 5'd5; prog_din = 8'h66;
        @(negedge clk);
        rst = 1'b0; prog_we = 1'b0;
        peek(5, d);
        n_checks++;
        if (d !== 8'h55) begin
            $display("FAIL reset_write_suppress got %h exp 55", d);
            n_fail++;
        end
    endtask

    task automatic test_add_flags();
        int e; logic d0, b0; logic [7:0] d;
        load(0, 8'h10); load(1, 8'h51); load(2, 8'h32); load(3, 8'hE0);
        load(16, 8'h7F); load(17, 8'h81);
        run_prog(e, d0, b0);
        n_checks++;
        if (e !== 8) begin
            $display("FAIL add_cycles got %0d exp 8", e); n_fail++;
        end
        n_checks++;
        if (b0 !== 1'b1 || d0 !== 1'b0) begin
            $display("FAIL add_busy_rise got b%b d%b exp b1 d0", b0, d0); n_fail++;
        end
        n_checks++;
        if (acc !== 8'h00 || zf !== 1'b1 || cf !== 1'b1 || pc !== 5'd4 || busy !== 1'b0) begin
            $display("FAIL add_result got acc=%h z%b c%b pc=%0d b%b exp acc=00 z1 c1 pc=4 b0",
                     acc, zf, cf, pc, busy);
            n_fail++;
        end
        peek(18, d);
        n_checks++;
        if (d !== 8'h00) begin
            $display("FAIL add_store got %h exp 00", d); n_fail++;
        end
    endtask

    task automatic test_countdown();
        int e; logic d0, b0; logic [7:0] d;
        load(0, 8'h14); load(1, 8'h75); load(2, 8'hC4);
        load(3, 8'hA1); load(4, 8'h36); load(5, 8'hE0);
        load(20, 3); load(21, 1); load(22, 8'hFF);
        run_prog(e, d0, b0);
        n_checks++;
        if (e !== 22) begin
            $display("FAIL loop_cycles got %0d exp 22", e); n_fail++;
        end
        n_checks++;
        if (acc !== 8'h00 || zf !== 1'b1 || cf !== 1'b1) begin
            $display("FAIL loop_result got acc=%h z%b c%b exp acc=00 z1 c1", acc, zf, cf);
            n_fail++;
        end
        peek(22, d);
        n_checks++;
        if (d !== 8'h00) begin
            $display("FAIL loop_store got %h exp 00", d); n_fail++;
        end
    endtask

    task automatic test_busy_gating();
        int e; logic [7:0] d;
        load(0, 8'h10); load(1, 8'h51); load(2, 8'h32); load(3, 8'hE0);
        load(16, 8'h7F); load(17, 8'h81); load(18, 8'h99);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        repeat (3) begin @(negedge clk); e++; end
        prog_we = 1'b1; prog_adr = 5'd16; prog_din = 8'hAA; start = 1'b1;
        n_checks++;
        #1;
        if (mem_wr !== 1'b0) begin
            $display("FAIL gate_mem_wr got %b exp 0", mem_wr); n_fail++;
        end
        @(negedge clk);
        e++;
        prog_we = 1'b0; start = 1'b0;
        while (done !== 1'b1 && e < LIMIT) begin
            @(negedge clk);
            e++;
        end
        n_checks++;
        if (e !== 8) begin
            $display("FAIL gate_cycles got %0d exp 8", e); n_fail++;
        end
        peek(16, d);
        n_checks++;
        if (d !== 8'h7F || acc !== 8'h00 || zf !== 1'b1 || cf !== 1'b1) begin
            $display("FAIL gate_mem16 got m=%h acc=%h z%b c%b exp m=7f acc=00 z1 c1",
                     d, acc, zf, cf);
            n_fail++;
        end
    endtask

    task automatic test_and_reload();
        int e; logic d0, b0;
        load(0, 8'h1E); load(1, 8'h9D); load(2, 8'hE0);
        load(30, 8'hF0); load(29, 8'h3C);
        for (int r = 0; r < 2; r++) begin
            run_prog(e, d0, b0);
            n_checks++;
            if (e !== 6 || d0 !== 1'b0 || b0 !== 1'b1) begin
                $display("FAIL and_run%0d got e=%0d d%b b%b exp e=6 d0 b1", r, e, d0, b0);
                n_fail++;
            end
            n_checks++;
            if (acc !== 8'h30 || zf !== 1'b0 || cf !== 1'b0) begin
                $display("FAIL and_result%0d got acc=%h z%b c%b exp acc=30 z0 c0",
                         r, acc, zf, cf);
                n_fail++;
            end
        end
    endtask

    task automatic test_pc_wrap_reset();
        logic [7:0] d;
        load(0, 8'hBF); load(31, 8'hBF);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pc !== 5'd0 || busy !== 1'b1) begin
            $display("FAIL wrap_pc got pc=%0d b%b exp pc=0 b1", pc, busy); n_fail++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        peek(31, d);
        n_checks++;
        if (busy !== 1'b0 || pc !== 5'd0 || acc !== 8'd0 || done !== 1'b0 || d !== 8'hBF) begin
            $display("FAIL wrap_reset got b%b pc=%0d acc=%h d%b m31=%h exp b0 pc=0 acc=00 d0 m31=bf",
                     busy, pc, acc, done, d);
            n_fail++;
        end
    endtask

    task automatic test_load_idle();
        int e;
        @(negedge clk);
        prog_we = 1'b1; prog_adr = 5'd0; prog_din = 8'hE0; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        ref_mem[0] = 8'hE0;
        e = 0;
        while (done !== 1'b1 && e < LIMIT) begin
            @(negedge clk);
            e++;
        end
        n_checks++;
        if (e !== 2 || pc !== 5'd1) begin
            $display("FAIL load_idle got e=%0d pc=%0d exp e=2 pc=1", e, pc); n_fail++;
        end
    endtask

    task automatic test_random();
        int e, len, op; logic d0, b0; logic [7:0] d;
        for (int t = 0; t < 15; t++) begin
            for (int a = 0; a < 32; a++) load(a, $urandom_range(0, 255));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                op = $urandom_range(0, 4);
                load(i, op * 32 + $urandom_range(16, 31));
            end
            load(len, 8'hE0);
            model_run();
            run_prog(e, d0, b0);
            n_checks++;
            if (e !== 2 * m_steps) begin
                $display("FAIL rand%0d_cycles got %0d exp %0d", t, e, 2 * m_steps); n_fail++;
            end
            n_checks++;
            if (acc !== 8'(m_acc) || zf !== m_zf || cf !== m_cf || pc !== 5'(m_pc)) begin
                $display("FAIL rand%0d_state got acc=%h z%b c%b pc=%0d exp acc=%h z%b c%b pc=%0d",
                         t, acc, zf, cf, pc, 8'(m_acc), m_zf, m_cf, m_pc);
                n_fail++;
            end
            for (int a = 16; a < 32; a++) begin
                peek(a, d);
                n_checks++;
                if (d !== 8'(ref_mem[a])) begin
                    $display("FAIL rand%0d_mem%0d got %h exp %h", t, a, d, 8'(ref_mem[a]));
                    n_fail++;
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) ref_mem[a] = 0;
        test_reset();
        test_add_flags();
        test_countdown();
        test_busy_gating();
        test_and_reload();
        test_pc_wrap_reset();
        test_load_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_proc_param.md
# acc_proc_param

Parametrised accumulator processor. It replaces the fixed 8-bit / 64-word, 2-opcode machine with a configurable data and address width. It adds an 8-instruction ISA, zero/carry flags, a start/busy/done handshake and a program-load port into its internal memory. It runs on a single clock edge and is the processor core the system-level bench instantiates.

## Interface
- DW, 8: data and instruction word width; must satisfy DW >= AW+3.
- AW, 5: address width; memory depth is 2^AW words.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin execution at address 0; sampled only when not busy.
- prog_we  in  1  program-port write strobe; honoured only when not busy.
- prog_adr  in  AW  program-port address.
- prog_din  in  DW  program-port write data.
- prog_dout  out  DW  mem[prog_adr], combinational.
- busy  out  1  high in FETCH/EXEC.
- done  out  1  high in DONE.
- acc  out  DW  accumulator.
- pc  out  AW  program counter.
- zf, cf  out  1  zero and carry flags.
- mem_adr  out  AW  address currently driving memory.
- mem_rd, mem_wr  out  1  memory read and write qualifiers, for observation.

## Operation
- Memory: 2^AW x DW array. Reads are asynchronous. Writes are synchronous, from STA or the program port. Memory is not cleared by rst.
- Instruction format:
  - Opcode is ir[DW-1:DW-3].
  - Operand address is ir[AW-1:0].
  - Any bits in between are ignored.
- Opcodes:
  - 000 LDA: acc=M.
  - 001 STA: M=acc.
  - 010 ADD: acc=acc+M.
  - 011 SUB: acc=acc+~M+1.
  - 100 AND: acc=acc&M.
  - 101 JMP: pc=adr.
  - 110 JZ: pc=adr if zf.
  - 111 HLT.
- Flags:
  - zf = (new acc == 0) after LDA, ADD, SUB and AND.
  - cf = carry out of the DW-bit sum after ADD and SUB. For SUB, cf=1 means no borrow.
  - AND and LDA leave cf unchanged.
  - STA, JMP, JZ and HLT leave both flags unchanged.
- Arithmetic is modulo 2^DW. pc increments modulo 2^AW, so pc wraps from 2^AW-1 to 0.
- FSM states: IDLE, FETCH, EXEC, DONE.
  - IDLE / DONE with start=1: clear pc, acc, ir and flags, then go to FETCH. done drops on the same edge.
  - FETCH: ir <= mem[pc], pc <= pc+1, go to EXEC.
  - EXEC: perform the opcode. HLT goes to DONE; every other opcode goes to FETCH.
- Memory bus:
  - In FETCH: mem_adr=pc, mem_rd=1.
  - In EXEC: mem_adr=ir address. mem_rd=1 for LDA/ADD/SUB/AND. mem_wr=1 for STA.
  - Otherwise: mem_adr=prog_adr, mem_rd=0, mem_wr=prog_we.
- Port gating while busy:
  - start is ignored.
  - prog_we is ignored, and mem_wr stays 0 outside STA.
- Same-cycle events:
  - prog_we and start in the same IDLE cycle: both are accepted. The first FETCH sees the written data.
  - rst with anything else: rst wins.

## Timing
- Reset values: state IDLE; pc=0, acc=0, ir=0, zf=0, cf=0, busy=0, done=0, mem_rd=0. Memory contents are unchanged.
- Every instruction takes exactly 2 cycles (FETCH + EXEC). A program of N executed instructions ending in HLT raises done N*2 edges after the edge that samples start.
- busy rises on the edge that samples start. busy falls and done rises on the HLT EXEC edge.
- rst mid-operation: the next edge returns to IDLE with reset values. A memory write in that same cycle is suppressed.

## Test plan
Parameters DW=8, AW=5 throughout; instruction word is {op[2:0], adr[4:0]}.
- Add with flags: load mem[0..3] = 0x10, 0x51, 0x32, 0xE0 and mem[16]=0x7F, mem[17]=0x81, then pulse start -> done 8 edges later; acc=0x00, zf=1, cf=1, mem[18]=0x00, pc=4.
- Countdown loop: load mem[0..5] = 0x14, 0x75, 0xC4, 0xA1, 0x36, 0xE0 and mem[20]=3, mem[21]=1 -> done 22 edges after start; acc=0, zf=1, cf=1, mem[22]=0.
- Busy gating: during the add program, pulse prog_we with prog_adr=16, prog_din=0xAA and pulse start again -> mem[16] stays 0x7F; result and cycle count are unchanged.
- AND and reload: mem[0..2] = 0x1E, 0x9D, 0xE0 with mem[30]=0xF0, mem[29]=0x3C -> acc=0x30, zf=0, cf=0. A second start from DONE re-runs the program and gives the same result.
- PC wrap and reset mid-run: mem[0]=0xBF and mem[31]=0xBF -> after the FETCH at address 31, pc=0. Assert rst during the following EXEC -> next edge gives busy=0, pc=0, acc=0, done=0, and prog_dout at address 31 still reads 0xBF.
- Load during idle: prog_we and start in the same cycle with prog_adr=0, prog_din=0xE0 -> done 2 edges later.
